// File: rtl/spi_burst_seq.sv
// Burst sequencer driving the SysIO SPI peripheral register port: host-side TX/RX byte FIFOs
// plus an FSM that runs load/enable/poll/read for each byte of an N-byte burst.
module spi_burst_seq #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  FILL_BYTE  = 8'hFF,
    parameter int          START_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    output logic [7:0]  spi_waddr_o,
    output logic [31:0] spi_wdata_o,
    output logic [3:0]  spi_sel_o,
    output logic        spi_we_o,
    output logic [7:0]  spi_raddr_o,
    output logic        spi_rd_o,
    input  logic [31:0] spi_rdata_i,
    output logic        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(START_WAIT + 1);

    localparam logic [4:0] REG_CFG    = 5'h00;
    localparam logic [4:0] REG_LEN    = 5'h04;
    localparam logic [4:0] REG_TXDATA = 5'h08;
    localparam logic [4:0] REG_RXDATA = 5'h0C;
    localparam logic [4:0] REG_STAT   = 5'h10;

    localparam logic [7:0] SPI_CTRL   = 8'h00;
    localparam logic [7:0] SPI_DATA   = 8'h04;
    localparam logic [7:0] SPI_STATUS = 8'h08;

    typedef enum logic [3:0] {
        S_IDLE, S_CSON, S_LOAD, S_GO, S_WAIT, S_PRD, S_PCHK, S_DRD, S_DCAP, S_CSOFF
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [WW-1:0]  wait_q, wait_d;

    logic           cpol_q, cpha_q, keep_cs_q;
    logic [7:0]     div_q, len_q;
    logic           tx_ovf_q, rx_ovf_q;
    logic [31:0]    data_q, rdata_d;

    logic [7:0]     tx_mem [FIFO_DEPTH];
    logic [AW-1:0]  tx_wptr_q, tx_rptr_q;
    logic [AW:0]    tx_cnt_q;
    logic [7:0]     rx_mem [FIFO_DEPTH];
    logic [AW-1:0]  rx_wptr_q, rx_rptr_q;
    logic [AW:0]    rx_cnt_q;

    logic busy, tx_full, tx_empty, rx_full, rx_empty;
    logic wr_cfg, wr_len, wr_stat, start, tx_push_req, tx_push, tx_pop;
    logic rx_push_req, rx_push, rx_pop;
    logic [31:0] base_ctrl;
    logic unused_bits;

    assign busy     = (state_q != S_IDLE);
    assign tx_full  = (tx_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign wr_cfg      = we_i && (waddr_i[4:0] == REG_CFG) && !busy;
    assign wr_len      = we_i && (waddr_i[4:0] == REG_LEN) && !busy;
    assign wr_stat     = we_i && (waddr_i[4:0] == REG_STAT);
    assign start       = wr_stat && data_i[31];
    assign tx_push_req = we_i && (waddr_i[4:0] == REG_TXDATA);
    assign tx_push     = tx_push_req && !tx_full;
    assign rx_push     = rx_push_req && !rx_full;
    assign rx_pop      = rd_i && (raddr_i[4:0] == REG_RXDATA) && !rx_empty;

    assign base_ctrl = {16'h0, div_q, 4'h0, 1'b0, cpha_q, cpol_q, 1'b0};

    assign data_o    = data_q;
    assign busy_o    = busy;
    assign spi_sel_o = 4'hF;

    assign unused_bits = ^{data_i[30:16], spi_rdata_i[31:8], waddr_i[7:5], raddr_i[7:5]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        spi_we_o    = 1'b0;
        spi_waddr_o = '0;
        spi_wdata_o = '0;
        spi_rd_o    = 1'b0;
        spi_raddr_o = '0;
        tx_pop      = 1'b0;
        rx_push_req = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (len_q != 8'd0)) begin
                    cnt_d   = len_q;
                    state_d = S_CSON;
                end
            end
            S_CSON: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = SPI_CTRL;
                spi_wdata_o = base_ctrl | 32'h8;
                state_d     = S_LOAD;
            end
            S_LOAD: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = SPI_DATA;
                spi_wdata_o = {24'h0, tx_empty ? FILL_BYTE : tx_mem[tx_rptr_q]};
                tx_pop      = !tx_empty;
                state_d     = S_GO;
            end
            S_GO: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = SPI_CTRL;
                spi_wdata_o = base_ctrl | 32'h9;
                wait_d      = WW'(START_WAIT);
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_PRD;
                else              wait_d  = wait_q - WW'(1);
            end
            S_PRD: begin
                spi_rd_o    = 1'b1;
                spi_raddr_o = SPI_STATUS;
                state_d     = S_PCHK;
            end
            // Peripheral read data arrives the cycle after the strobe, so it is used directly here.
            S_PCHK: state_d = spi_rdata_i[0] ? S_PRD : S_DRD;
            S_DRD: begin
                spi_rd_o    = 1'b1;
                spi_raddr_o = SPI_DATA;
                state_d     = S_DCAP;
            end
            S_DCAP: begin
                rx_push_req = 1'b1;
                cnt_d       = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = keep_cs_q ? S_IDLE : S_CSOFF;
                else               state_d = S_LOAD;
            end
            S_CSOFF: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = SPI_CTRL;
                spi_wdata_o = base_ctrl;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: FIFO storage is not reset; the pointers and counts alone define empty.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= data_i[7:0];
        if (rx_push) rx_mem[rx_wptr_q] <= spi_rdata_i[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
            tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
            rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    always_comb begin
        rdata_d = '0;
        case (raddr_i[4:0])
            REG_CFG:    rdata_d = {16'h0, div_q, 4'h0, keep_cs_q, cpha_q, cpol_q, 1'b0};
            REG_LEN:    rdata_d = {24'h0, len_q};
            REG_RXDATA: rdata_d = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr_q]};
            REG_STAT:   rdata_d = {8'h0, {(7-AW){1'b0}}, rx_cnt_q, {(7-AW){1'b0}}, tx_cnt_q,
                                   5'h0, rx_ovf_q, tx_ovf_q, busy};
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            keep_cs_q <= 1'b0;
            div_q     <= '0;
            len_q     <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            if (wr_cfg) begin
                cpol_q    <= data_i[1];
                cpha_q    <= data_i[2];
                keep_cs_q <= data_i[3];
                div_q     <= data_i[15:8];
            end
            if (wr_len) len_q <= data_i[7:0];
            // A new overflow event wins over a simultaneous clear.
            if (tx_push_req && tx_full)      tx_ovf_q <= 1'b1;
            else if (wr_stat && data_i[1])   tx_ovf_q <= 1'b0;
            if (rx_push_req && rx_full)      rx_ovf_q <= 1'b1;
            else if (wr_stat && data_i[2])   rx_ovf_q <= 1'b0;
            if (rd_i) data_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_burst_seq.sv
// Self-checking bench for spi_burst_seq: a behavioural SPI peripheral echoing nibble-swapped
// bytes, a write-order scoreboard, an RX scoreboard and a register vector table.
module tb_spi_burst_seq;

    localparam logic [7:0] A_CFG = 8'h00, A_LEN = 8'h04, A_TX = 8'h08, A_RX = 8'h0C, A_STAT = 8'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic        we_i = 1'b0;
    logic [7:0]  raddr_i = '0;
    logic        rd_i = 1'b0;
    logic [31:0] data_o;
    logic [7:0]  spi_waddr_o;
    logic [31:0] spi_wdata_o;
    logic [3:0]  spi_sel_o;
    logic        spi_we_o;
    logic [7:0]  spi_raddr_o;
    logic        spi_rd_o;
    logic [31:0] spi_rdata_i;
    logic        busy_o;

    spi_burst_seq dut (
        .clk(clk), .rst(rst), .waddr_i(waddr_i), .data_i(data_i), .we_i(we_i),
        .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o), .spi_waddr_o(spi_waddr_o),
        .spi_wdata_o(spi_wdata_o), .spi_sel_o(spi_sel_o), .spi_we_o(spi_we_o),
        .spi_raddr_o(spi_raddr_o), .spi_rd_o(spi_rd_o), .spi_rdata_i(spi_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_wr[$];
    logic [7:0]  rx_exp[$];
    logic [7:0]  tx_model[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] echo(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    // Behavioural SPI peripheral: EN starts a transfer lasting a random number of cycles.
    logic [31:0] sl_ctrl;
    logic [7:0]  sl_tx, sl_rx;
    int          sl_busy;
    logic        sl_ss_n;
    assign sl_ss_n = ~sl_ctrl[3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_ctrl     <= '0;
            sl_tx       <= '0;
            sl_rx       <= '0;
            sl_busy     <= 0;
            spi_rdata_i <= '0;
        end else begin
            if (sl_busy > 0) begin
                sl_busy <= sl_busy - 1;
                if (sl_busy == 1) sl_rx <= echo(sl_tx);
            end
            if (spi_we_o) begin
                if (spi_waddr_o == 8'h00) begin
                    sl_ctrl <= spi_wdata_o;
                    if (spi_wdata_o[0]) sl_busy <= 4 + int'($urandom_range(0, 6));
                end else if (spi_waddr_o == 8'h04) begin
                    sl_tx <= spi_wdata_o[7:0];
                end
            end
            spi_rdata_i <= 32'hDEAD_BEEF;
            if (spi_rd_o) begin
                case (spi_raddr_o)
                    8'h08:   spi_rdata_i <= {31'h0, sl_busy != 0};
                    8'h04:   spi_rdata_i <= {24'h0, sl_rx};
                    default: spi_rdata_i <= sl_ctrl;
                endcase
            end
        end
    end

    // Write-order scoreboard: every peripheral write must match the next expected one.
    always @(negedge clk) begin
        if (!rst && spi_we_o) begin
            if (exp_wr.size() == 0) check("spi_wr_unexpected", {spi_waddr_o, spi_wdata_o}, 40'h0);
            else                    check("spi_wr_order", {spi_waddr_o, spi_wdata_o}, exp_wr.pop_front());
        end
    end

    task automatic host_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        waddr_i = a; data_i = d; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        raddr_i = a; rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        d = data_o;
    endtask

    task automatic push_tx(input logic [7:0] b);
        host_write(A_TX, {24'h0, b});
        if (tx_model.size() < 8) tx_model.push_back(b);
    endtask

    task automatic read_rx(input string name);
        logic [31:0] d;
        logic [7:0]  e;
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
        host_read(A_RX, d);
        check(name, d, {24'h0, e});
    endtask

    task automatic expect_burst(input logic [31:0] cfg, input int len);
        logic [31:0] base;
        logic [7:0]  b;
        base = {16'h0, cfg[15:8], 4'h0, 1'b0, cfg[2], cfg[1], 1'b0};
        exp_wr.push_back({8'h00, base | 32'h8});
        for (int i = 0; i < len; i++) begin
            b = (tx_model.size() != 0) ? tx_model.pop_front() : 8'hFF;
            exp_wr.push_back({8'h04, 24'h0, b});
            exp_wr.push_back({8'h00, base | 32'h9});
            if (rx_exp.size() < 8) rx_exp.push_back(echo(b));
        end
        if (!cfg[3]) exp_wr.push_back({8'h00, base});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy_o, 1'b0);
        check({name, "_wr_drained"}, exp_wr.size(), 0);
    endtask

    task automatic run_burst(input string name, input logic [31:0] cfg, input int len);
        host_write(A_CFG, cfg);
        host_write(A_LEN, len);
        expect_burst(cfg, len);
        host_write(A_STAT, 32'h8000_0000);
        check({name, "_busy_rise"}, busy_o, 1'b1);
        wait_idle(name);
    endtask

    typedef struct {
        logic        do_wr;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        logic [31:0] d;
        int          dcount;
        bit          hit;

        vecs[0] = '{1'b1, A_CFG,  32'hFFFF_A50F, A_CFG,  32'h0000_A50E};
        vecs[1] = '{1'b1, A_LEN,  32'h1234_5607, A_LEN,  32'h0000_0007};
        vecs[2] = '{1'b0, 8'h00,  32'h0,         8'h14,  32'h0};
        vecs[3] = '{1'b0, 8'h00,  32'h0,         A_RX,   32'h0};
        vecs[4] = '{1'b1, A_LEN,  32'h0,         A_LEN,  32'h0};
        vecs[5] = '{1'b1, A_STAT, 32'h8000_0000, A_STAT, 32'h0};
        vecs[6] = '{1'b0, 8'h00,  32'h0,         8'h20,  32'h0000_A50E};
        vecs[7] = '{1'b0, 8'h00,  32'h0,         A_TX,   32'h0};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {data_o, spi_waddr_o, spi_wdata_o, spi_we_o, spi_raddr_o, spi_rd_o, busy_o},
              '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) host_write(vecs[i].waddr, vecs[i].wdata);
            host_read(vecs[i].raddr, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        check("start_len0_idle", busy_o, 1'b0);

        // Basic two-byte burst; CFG/LEN writes mid-burst must be ignored.
        push_tx(8'hA5);
        push_tx(8'h3C);
        host_write(A_CFG, 32'h0);
        host_write(A_LEN, 32'd2);
        expect_burst(32'h0, 2);
        host_write(A_STAT, 32'h8000_0000);
        check("t1_busy_rise", busy_o, 1'b1);
        host_write(A_CFG, 32'h0000_FF0E);
        host_write(A_LEN, 32'd9);
        wait_idle("t1");
        check("t1_ss_released", sl_ss_n, 1'b1);
        read_rx("t1_rx0");
        read_rx("t1_rx1");
        host_read(A_CFG, d);
        check("t1_cfg_locked", d, 32'h0);
        host_read(A_LEN, d);
        check("t1_len_locked", d, 32'd2);
        check("spi_sel", spi_sel_o, 4'hF);

        // Empty TX FIFO sends the fill byte; non-zero DIV/CPOL in CTRL.
        run_burst("t2", 32'h0000_0402, 3);
        host_read(A_STAT, d);
        check("t2_stat", d, 32'h0003_0000);
        for (int i = 0; i < 3; i++) read_rx($sformatf("t2_rx%0d", i));
        repeat (3) @(negedge clk);
        check("t2_data_hold", data_o, 32'h0000_00FF);

        // KEEP_CS: no closing CTRL write, chip select stays active.
        push_tx(8'h81);
        run_burst("t3", 32'h0000_0008, 1);
        check("t3_ss_held", sl_ss_n, 1'b0);
        read_rx("t3_rx");

        // TX overflow and clear.
        for (int i = 0; i < 9; i++) push_tx(8'h10 + 8'(i));
        host_read(A_STAT, d);
        check("t4_stat_ovf", d, 32'h0000_0802);
        host_write(A_STAT, 32'h0000_0002);
        host_read(A_STAT, d);
        check("t4_stat_clr", d, 32'h0000_0800);

        // Fill RX with 8 bytes, then a 2-byte burst whose bytes are dropped.
        run_burst("t5a", 32'h0, 8);
        host_read(A_STAT, d);
        check("t5_stat_full", d, 32'h0008_0000);
        run_burst("t5b", 32'h0, 2);
        host_read(A_STAT, d);
        check("t5_stat_rxovf", d, 32'h0008_0004);
        for (int i = 0; i < 8; i++) read_rx($sformatf("t5_rx%0d", i));
        read_rx("t5_rx_empty");
        host_write(A_STAT, 32'h0000_0004);
        host_read(A_STAT, d);
        check("t5_stat_clr", d, 32'h0);

        // Reset during the status poll of byte 2 of 4.
        for (int i = 0; i < 4; i++) push_tx(8'hC0 + 8'(i));
        host_write(A_LEN, 32'd4);
        expect_burst(32'h0, 4);
        host_write(A_STAT, 32'h8000_0000);
        dcount = 0;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (spi_we_o && spi_waddr_o == 8'h04) dcount++;
            if (dcount == 2 && spi_rd_o && spi_raddr_o == 8'h08) hit = 1'b1;
        end
        check("t6_prd_reached", hit, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_reset_outputs",
              {data_o, spi_waddr_o, spi_wdata_o, spi_we_o, spi_raddr_o, spi_rd_o, busy_o},
              '0);
        exp_wr.delete();
        rx_exp.delete();
        tx_model.delete();
        @(negedge clk);
        rst = 1'b0;
        host_read(A_STAT, d);
        check("t6_stat_after_rst", d, 32'h0);
        host_read(A_CFG, d);
        check("t6_cfg_after_rst", d, 32'h0);
        push_tx(8'h66);
        run_burst("t6_new", 32'h0, 1);
        read_rx("t6_rx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_seq.md
Name: spi_burst_seq

Overview:
- Bus-master sequencer that sits directly upstream of the SysIO SPI peripheral and drives that peripheral's register port.
- The CPU queues bytes in a TX FIFO and starts a burst of N bytes. The block then runs each byte through the SPI peripheral (load DATA, pulse enable, poll STATUS, read DATA) and pushes each received byte into an RX FIFO.
- Chip select stays asserted for the whole burst. The CPU is freed from per-byte polling.

Parameters:
FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs (power of 2, 2..64)
FILL_BYTE, 8'hFF, byte transmitted when the TX FIFO is empty during a burst
START_WAIT, 3, cycles between the enable write and the first STATUS poll

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
waddr_i  in  8  host write address
data_i  in  32  host write data
we_i  in  1  host write strobe
raddr_i  in  8  host read address
rd_i  in  1  host read strobe
data_o  out  32  host read data, registered
spi_waddr_o  out  8  SPI peripheral write address
spi_wdata_o  out  32  SPI peripheral write data
spi_sel_o  out  4  SPI peripheral byte select, always 4'hF
spi_we_o  out  1  SPI peripheral write strobe
spi_raddr_o  out  8  SPI peripheral read address
spi_rd_o  out  1  SPI peripheral read strobe
spi_rdata_i  in  32  SPI peripheral read data; valid the cycle after spi_rd_o
busy_o  out  1  burst in progress

Behaviour:
Reset (async):
- All outputs 0, FIFOs empty, registers 0, state IDLE.
- Reset mid-burst aborts immediately; the spi_ss level is then set by the SPI peripheral's own reset.

Host registers (decode on addr[4:0]):
- 0x00 CFG (R/W): [1] CPOL, [2] CPHA, [3] KEEP_CS, [15:8] DIV.
  - Writes are ignored while busy.
- 0x04 LEN (R/W): [7:0] byte count.
  - 0 means "do nothing".
  - Writes are ignored while busy.
- 0x08 TXDATA (W): pushes data_i[7:0].
  - Push when full: drop the byte and set TX_OVF.
- 0x0C RXDATA (R): returns {24'h0, head} and pops.
  - Read when empty: returns 0, no pop.
- 0x10 STAT:
  - Read: [0] busy, [1] TX_OVF, [2] RX_OVF, [15:8] tx_count, [23:16] rx_count.
  - Write: bit 31 = start. Writing 1 to bit1 clears TX_OVF; writing 1 to bit2 clears RX_OVF.
- data_o is registered, valid the cycle after rd_i, and holds otherwise. Unmapped addresses read 0.
- A simultaneous FIFO push and pop in the same cycle is legal; the count is unchanged.

Master transactions:
- Write: one-cycle spi_we_o pulse with address and data stable in that cycle.
- Read: one-cycle spi_rd_o pulse; sample spi_rdata_i the next cycle.
- SPI peripheral offsets: CTRL 0x00, DATA 0x04, STATUS 0x08.
- Let base = {16'h0, DIV, 4'b0, CS, CPHA, CPOL, EN}.

FSM:
- IDLE: on start with LEN != 0, latch cnt = LEN, set busy, go to CSON. Start with LEN == 0 is ignored.
- CSON: write CTRL = base with CS=1, EN=0. Go to LOAD.
- LOAD: write DATA = tx head (pop), or FILL_BYTE if the TX FIFO is empty. Go to GO.
- GO: write CTRL with CS=1, EN=1. Load the wait counter with START_WAIT. Go to WAIT.
- WAIT: count down to 0, then go to PRD.
- PRD: read STATUS. Go to PCHK.
- PCHK: if bit0 = 1, go to PRD; else go to DRD.
- DRD: read DATA. Go to DCAP.
- DCAP: push byte [7:0] into the RX FIFO.
  - If the RX FIFO is full: drop the byte and set RX_OVF; the burst continues.
  - Decrement cnt. If cnt becomes 0: go to IDLE if KEEP_CS = 1, else go to CSOFF. Otherwise go to LOAD.
- CSOFF: write CTRL with CS=0, EN=0. Go to IDLE and clear busy.

Other rules:
- busy_o equals STAT[0]. It rises the cycle after the start write and falls on entry to IDLE.
- The poll loop has no timeout.
- START_WAIT must be ≥ 3, which covers the SPI peripheral's two-cycle status lag.

Test Plan:
1. Push A5, 3C; LEN=2, CPHA=0, DIV=0; start.
   - Required: SPI writes in the order CTRL(0x08), DATA(A5), CTRL(0x09), …, DATA(3C), CTRL(0x09), …, CTRL(0x00).
   - Slave echoes 5A, C3 → RX returns 5A then C3; busy drops after CSOFF.
2. TX FIFO empty; LEN=3; start → three DATA writes of 0xFF; rx_count = 3.
3. KEEP_CS=1, LEN=1 → no final CTRL(CS=0) write; spi_ss stays low after busy falls.
4. Push 9 bytes with FIFO_DEPTH=8 → tx_count = 8, TX_OVF = 1; writing STAT with bit1 = 1 clears it.
5. RX FIFO full with 8 entries, LEN=2 → both received bytes dropped, RX_OVF = 1, burst completes.
6. Assert rst during PRD of byte 2 of 4 → all outputs 0, busy 0, FIFOs empty the same cycle; a new burst afterwards works normally.
